// File: rtl/nand_chain_checker_pkg.sv
// Shared definitions for the NAND chain checker.
//   - FSM state encoding (3-bit): IDLE=0, DRIVE=1, SETTLE=2, CHECK=3, DONE=4
//   - Vector index width and failure-capture record width
//   - Golden functions for the two-stage cascaded NAND cell:
//       d = ~(a & b),  e = ~(c & d) = ~c | (a & b)
package nand_chain_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int VEC_W = 3;
  // {vec_idx, dut_d, dut_e}
  localparam int FAIL_W = VEC_W + 2;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  function automatic logic golden_d(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic golden_e(input logic a, input logic b, input logic c);
    return ~c | (a & b);
  endfunction

endpackage

// File: rtl/nand_chain_checker_if.sv
// Controller-side handshake and result bus of the NAND chain checker.
//   start      controller -> checker  request a full sweep
//   busy       checker -> controller  sweep in progress
//   done       checker -> controller  sweep finished, results valid
//   pass       checker -> controller  1 when no vector mismatched
//   err_count  checker -> controller  saturating mismatch count (ERR_W bits)
//   vec_idx    checker -> controller  current vector {a,b,c}
// With NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN defined, also:
//   fail_valid / fail_vec  first-mismatch flag and {vec_idx, d, e} record
// Modports: master = controller, slave = checker.
interface nand_chain_checker_if #(
  parameter int ERR_W = 4
);
  import nand_chain_checker_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [VEC_W-1:0] vec_idx;
`ifdef NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN
  logic              fail_valid;
  logic [FAIL_W-1:0] fail_vec;

  modport master (output start,
                  input  busy, done, pass, err_count, vec_idx, fail_valid, fail_vec);
  modport slave  (input  start,
                  output busy, done, pass, err_count, vec_idx, fail_valid, fail_vec);
`else
  modport master (output start,
                  input  busy, done, pass, err_count, vec_idx);
  modport slave  (input  start,
                  output busy, done, pass, err_count, vec_idx);
`endif

endinterface

// File: rtl/nand_chain_checker_golden.sv
// Combinational golden model of the cascaded NAND cell.
//   a, b, c        cell inputs
//   exp_d, exp_e   expected cell outputs
module nand_chain_golden
  import nand_chain_checker_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_d,
  output logic exp_e
);

  assign exp_d = golden_d(a, b);
  assign exp_e = golden_e(a, b, c);

endmodule

// File: rtl/nand_chain_checker.sv
// Stimulus driver and response checker for the cascaded NAND cell.
// Sweeps {a,b,c} = 0..7, waits SETTLE_CYCLES after driving each vector,
// compares the cell's d/e against the golden model and counts mismatches.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        nand_chain_checker_if.slave (start/busy/done/pass/err_count/vec_idx)
//   dut_d      cell output d
//   dut_e      cell output e
//   a, b, c    registered cell inputs
// Optional: define NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN to capture the first
// mismatching vector on bus.fail_valid / bus.fail_vec.
module nand_chain_checker
  import nand_chain_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nand_chain_checker_if.slave  bus,
  input  logic                 dut_d,
  input  logic                 dut_e,
  output logic                 a,
  output logic                 b,
  output logic                 c
);

  // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             exp_d;
  logic             exp_e;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  nand_chain_golden u_golden (
    .a     (a),
    .b     (b),
    .c     (c),
    .exp_d (exp_d),
    .exp_e (exp_e)
  );

  assign mismatch = (dut_d != exp_d) || (dut_e != exp_e);
  // Saturating increment; pass is derived from this so it reflects the last vector.
  assign err_next = (mismatch && (bus.err_count != ERR_MAX)) ? bus.err_count + 1'b1
                                                              : bus.err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      a             <= 1'b0;
      b             <= 1'b0;
      c             <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
      bus.vec_idx   <= '0;
`ifdef NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN
      bus.fail_valid <= 1'b0;
      bus.fail_vec   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state         <= ST_DRIVE;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= '0;
            bus.vec_idx   <= '0;
`ifdef NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN
            bus.fail_valid <= 1'b0;
            bus.fail_vec   <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          {a, b, c}  <= bus.vec_idx;
          settle_cnt <= CNT_LOAD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          bus.err_count <= err_next;
`ifdef NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN
          if (mismatch && !bus.fail_valid) begin
            bus.fail_valid <= 1'b1;
            bus.fail_vec   <= {bus.vec_idx, dut_d, dut_e};
          end
`endif
          if (bus.vec_idx == LAST_VEC) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_next == '0);
          end else begin
            bus.vec_idx <= bus.vec_idx + 1'b1;
            state       <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nand_chain_checker.md
Name: nand_chain_checker

Overview:
- Sequential stimulus driver and response checker for the two-stage cascaded NAND cell: d = ~(a & b), e = ~(c & d).
- Sweeps all 8 input vectors {a,b,c}, waits a programmable settle time, samples the cell's d/e, compares against golden values and counts mismatches.
- Sits on the board or bench side as the exercising end of the gate cell: it drives the cell's inputs and consumes its outputs.
- Provides a start/busy/done handshake for a top-level controller or button FSM.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling the cell; legal values are 1 or more.
- ERR_W, 4, width of the mismatch counter; the counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  single system clock; all logic acts on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE or DONE.
- dut_d  input  1  cell output d.
- dut_e  input  1  cell output e.
- a  output  1  cell input a (registered).
- b  output  1  cell input b (registered).
- c  output  1  cell input c (registered).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid while done is high; 1 when err_count is 0.
- err_count  output  ERR_W  saturating count of mismatching vectors.
- vec_idx  output  3  index {a,b,c} of the current vector.

Behaviour:
- Reset: synchronous active-low. When rst_n is 0 at a clk edge, all outputs go to 0 and the FSM enters IDLE. This includes reset mid-sweep, where the sweep is abandoned and nothing is held over.
- States and transitions:
  - IDLE: start=1 clears err_count and vec_idx, then moves to DRIVE.
  - DRIVE: loads {a,b,c} <= vec_idx and the settle counter <= SETTLE_CYCLES-1, then moves to SETTLE.
  - SETTLE: decrements the counter and moves to CHECK when the counter is 0.
  - CHECK: compares the inputs against the expected values.
    - Expected d is ~(a&b). Expected e is ~c | (a&b).
    - On any mismatch, err_count increments unless it is already at max.
    - If vec_idx is 7, move to DONE. Otherwise vec_idx increments and the FSM returns to DRIVE.
  - DONE: done=1 and pass=(err_count==0). start=1 behaves as in IDLE: it clears done and the results and starts a new sweep.
- busy is 1 in DRIVE, SETTLE and CHECK only. start is ignored while busy.
- Latency:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - done rises 8*(SETTLE_CYCLES+2) cycles after the edge that accepted start. With defaults this is 32 cycles.
- Golden table, abc -> d,e: 000->1,1; 001->1,0; 010->1,1; 011->1,0; 100->1,1; 101->1,0; 110->0,1; 111->0,1.
- vec_idx wraps 7->0 only via a new start; it never overflows inside a sweep.
- start asserted in the same cycle the FSM enters DONE is not accepted; it is sampled from the following cycle.

Optional Feature:
- Macro: NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN.
- When defined, two extra outputs are added:
  - fail_valid (1 bit): set on the first mismatch of a sweep.
  - fail_vec (5 bits): holds {vec_idx, dut_d, dut_e} captured at that first mismatch.
- Both outputs hold until reset or the next accepted start, which clears them to 0.
- When not defined, these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package or include file holds:
  - FSM state encodings: IDLE=0, DRIVE=1, SETTLE=2, CHECK=3, DONE=4, 3-bit.
  - The golden-function definitions for the expected d and e.
- Sub-module: nand_chain_golden, a combinational block with inputs a,b,c and outputs exp_d,exp_e. It is instantiated in the checker and reused by the bench scoreboard.
- The FSM, settle counter and error counter live in the top module.

Test Plan:
- Correct cell model wired to the checker, start pulsed 1 cycle -> done=1 at cycle 32, pass=1, err_count=0, with vectors 0..7 driven in order.
- Cell d output stuck at 1 -> mismatches only at vectors 6 and 7; err_count=2, pass=0.
- ERR_W=1 with cell e inverted -> 8 mismatches; err_count saturates at 1 and does not wrap.
- rst_n=0 for 1 cycle while vec_idx=4 in SETTLE -> next cycle in IDLE with all outputs 0; a new start completes a clean sweep.
- start held high throughout the sweep -> ignored while busy. After done rises, start held high restarts the next cycle: done drops and err_count clears.
- With NAND_CHAIN_CHECKER_FAIL_CAPTURE_EN defined and e stuck at 0 -> fail_valid=1, fail_vec={3'b000,1,0} after the first check, and it is unchanged at done.
